l2_per_bridge_arbiter: RTL and testbench
========================================

# l2_per_bridge_arbiter

Round-robin arbiter that shares the single L2 peripheral-bridge port among N_MASTERS TCDM/peripheral demux instances. Each demux's PER-side request is presented here. The arbiter grants one request at a time to the bridge and tracks the single outstanding transaction. It steers the bridge response back to the master that owns it. It sits between the per-core demuxes and the AXI/APB bridge.

## Interface
- N_MASTERS, 4: number of requesting demux ports (≥2)
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 32: data width
- BE_WIDTH, DATA_WIDTH/8: byte-enable width
- TAG_WIDTH, DATA_WIDTH/8: tag width
- AUX_WIDTH, 4: aux sideband width
- TIMEOUT_CYCLES, 256: response watchdog limit; used only with the timeout feature
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- test_en_i  in  1  test mode; no functional effect
- m_req_i  in  N_MASTERS  per-master request
- m_add_i / m_wen_i / m_wdata_i / m_wtag_i / m_be_i / m_aux_i  in  N_MASTERS×(ADDR/1/DATA/TAG/BE/AUX)  per-master payload
- m_gnt_o  out  N_MASTERS  per-master grant
- m_r_valid_o  out  N_MASTERS  per-master response valid
- m_r_rdata_o / m_r_rtag_o / m_r_opc_o / m_r_aux_o  out  DATA/TAG/1/AUX  response payload, broadcast to all masters
- per_req_o  out  1  request to bridge
- per_add_o / per_wen_o / per_wdata_o / per_wtag_o / per_be_o / per_aux_o  out  ADDR/1/DATA/TAG/BE/AUX  payload to bridge
- per_gnt_i  in  1  bridge grant
- per_r_valid_i / per_r_rdata_i / per_r_rtag_i / per_r_opc_i / per_r_aux_i  in  1/DATA/TAG/1/AUX  bridge response

## Operation
- State: CS ∈ {IDLE, WAIT_RESP, ERR_RESP}. Registers: owner index (clog2(N_MASTERS) bits), rr_ptr (same width), owner_aux (AUX_WIDTH).
- **Arbitration (arb_en):** arb_en = (CS==IDLE) | (CS==WAIT_RESP & per_r_valid_i).
  - The winner is the first asserted m_req_i, scanning from rr_ptr upward with wrap-around.
  - When arb_en is set and any request is present:
    - per_req_o=1 and the per_* payload equals the winner's payload.
    - m_gnt_o[winner]=per_gnt_i; all other grants are 0.
- **Grant handshake:** on per_gnt_i=1 while per_req_o=1:
  - owner←winner; owner_aux←m_aux_i[winner]; rr_ptr←(winner+1) mod N_MASTERS; CS←WAIT_RESP.
  - Without a grant, no state changes. A requester may drop or change its request, because the winner is re-evaluated each cycle.
- **Default payload:** when no request is present, per_req_o=0 and the payload is master 0's payload.
- **WAIT_RESP:**
  - per_req_o=0 unless per_r_valid_i=1, in which case arb_en applies.
  - On per_r_valid_i=1:
    - m_r_valid_o[owner]=1 in the same cycle.
    - m_r_* = per_r_*.
    - Next state is IDLE if no new grant occurs that cycle. It stays WAIT_RESP with the new owner if a grant occurs (back-to-back).
- **Spurious response:** per_r_valid_i in IDLE is dropped; all m_r_valid_o stay 0.
- **Response payload:** m_r_rdata_o/rtag/opc/aux = per_r_* in IDLE and WAIT_RESP; only valid bits are per-master.
- **Concurrency:** at most one outstanding bridge transaction.
- **Reset mid-transaction:** returns to IDLE. A pending bridge response arriving after reset is dropped.

## Timing
- **Reset values:**
  - CS=IDLE, owner=0, rr_ptr=0, owner_aux=0.
  - All m_gnt_o=0, m_r_valid_o=0, per_req_o=0, m_r_opc_o=per_r_opc_i.
- **Combinational paths, zero latency:**
  - m_req_i → per_req_o.
  - per_gnt_i → m_gnt_o.
  - per_r_valid_i → m_r_valid_o.
- **Minimum transaction:** grant in cycle 0; response no earlier than cycle 1.
- **Back-to-back:** with continuous responses, one transaction per cycle is sustained.
- **Fairness:** with all N masters requesting continuously, each is granted exactly once in every N consecutive grants.

## Configuration
- Macro: L2_PER_ARB_TIMEOUT_EN.
- **Defined:**
  - A counter of clog2(TIMEOUT_CYCLES+1) bits clears on grant and increments each WAIT_RESP cycle without per_r_valid_i.
  - When it reaches TIMEOUT_CYCLES, CS←ERR_RESP.
  - In ERR_RESP:
    - m_r_valid_o[owner]=1, m_r_opc_o=1.
    - m_r_rdata_o=32'hBAD_ACCE5, zero-extended or truncated to DATA_WIDTH.
    - m_r_rtag_o='1, m_r_aux_o=owner_aux.
    - No arbitration; next state is IDLE.
  - A late bridge response then arrives in IDLE and is dropped.
- **Undefined:** no counter, ERR_RESP unreachable, and WAIT_RESP waits indefinitely.

## Test plan
- **Single request:** master 2 requests, per_gnt_i=1 in cycle 0, per_r_valid_i with rdata=0x1234_5678 in cycle 3 → m_gnt_o=4'b0100 in cycle 0; m_r_valid_o=4'b0100 only in cycle 3 with rdata 0x1234_5678; rr_ptr=3.
- **Round-robin:** all 4 masters request continuously, bridge grants and responds every cycle → grant order 0,1,2,3,0; m_gnt_o one-hot in each cycle.
- **Grant stall:** master 1 requests with per_gnt_i=0 for 5 cycles, then 1 → m_gnt_o=0 during the stall; owner=1 only after the grant; no response routed meanwhile.
- **Back-to-back:** response to master 0 and a new request from master 3 both arrive in the same cycle with a grant → m_r_valid_o[0]=1 and m_gnt_o[3]=1 together; CS stays WAIT_RESP with owner=3.
- **Spurious response:** per_r_valid_i=1 while in IDLE → m_r_valid_o=0.
- **Timeout (macro defined, TIMEOUT_CYCLES=8):** grant to master 1 with aux=0x5 and no response → in cycle 9, m_r_valid_o=4'b0010, opc=1, rdata=0xBAD_ACCE5, rtag all-ones, aux=0x5; CS=IDLE afterwards.

Source files
------------

// File: rtl/l2_per_bridge_arbiter.sv
// -----------------------------------------------------------------------------
// l2_per_bridge_arbiter
//
// Shares the single L2 peripheral-bridge port among N_MASTERS demux instances.
// A round-robin scan picks one requester per cycle. The handshake is presented
// to the bridge combinationally, and the grant is echoed back to the winner.
// Only one bridge transaction is outstanding at a time. The owner of that
// transaction is remembered so the bridge response can be steered back to it.
// A new grant may be issued in the same cycle as the response (back-to-back),
// which sustains one transaction per cycle.
//
// Optional feature (macro L2_PER_ARB_TIMEOUT_EN):
//   A response watchdog. If the bridge stays silent for TIMEOUT_CYCLES cycles
//   in WAIT_RESP, an error response (opc=1, rdata=BADACCE5, rtag all-ones,
//   aux=owner aux) is returned to the owner. Any late bridge response is then
//   dropped in IDLE. Without the macro, WAIT_RESP waits indefinitely.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   test_en_i           test mode (no functional effect)
//   m_req_i, m_*_i      per-master request and flattened payload (master k at slice k)
//   m_gnt_o             per-master grant (one-hot, combinational from per_gnt_i)
//   m_r_valid_o         per-master response valid (one-hot)
//   m_r_*_o             response payload, broadcast to all masters
//   per_req_o, per_*_o  request and payload towards the bridge
//   per_gnt_i           bridge grant
//   per_r_*_i           bridge response
// -----------------------------------------------------------------------------
module l2_per_bridge_arbiter #(
   parameter int unsigned N_MASTERS      = 4,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
   parameter int unsigned TAG_WIDTH      = DATA_WIDTH / 8,
   parameter int unsigned AUX_WIDTH      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            test_en_i,
   // master side requests
   input  logic [N_MASTERS-1:0]            m_req_i,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_add_i,
   input  logic [N_MASTERS-1:0]            m_wen_i,
   input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
   input  logic [N_MASTERS*TAG_WIDTH-1:0]  m_wtag_i,
   input  logic [N_MASTERS*BE_WIDTH-1:0]   m_be_i,
   input  logic [N_MASTERS*AUX_WIDTH-1:0]  m_aux_i,
   output logic [N_MASTERS-1:0]            m_gnt_o,
   // master side responses
   output logic [N_MASTERS-1:0]            m_r_valid_o,
   output logic [DATA_WIDTH-1:0]           m_r_rdata_o,
   output logic [TAG_WIDTH-1:0]            m_r_rtag_o,
   output logic                            m_r_opc_o,
   output logic [AUX_WIDTH-1:0]            m_r_aux_o,
   // bridge side request
   output logic                            per_req_o,
   output logic [ADDR_WIDTH-1:0]           per_add_o,
   output logic                            per_wen_o,
   output logic [DATA_WIDTH-1:0]           per_wdata_o,
   output logic [TAG_WIDTH-1:0]            per_wtag_o,
   output logic [BE_WIDTH-1:0]             per_be_o,
   output logic [AUX_WIDTH-1:0]            per_aux_o,
   input  logic                            per_gnt_i,
   // bridge side response
   input  logic                            per_r_valid_i,
   input  logic [DATA_WIDTH-1:0]           per_r_rdata_i,
   input  logic [TAG_WIDTH-1:0]            per_r_rtag_i,
   input  logic                            per_r_opc_i,
   input  logic [AUX_WIDTH-1:0]            per_r_aux_i
);

   localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
`ifdef L2_PER_ARB_TIMEOUT_EN
   localparam logic [1:0] ST_ERR  = 2'd2;

   localparam int unsigned           CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hBADACCE5);
`endif

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]           r_cs;
   logic [1:0]           w_cs_next;
   logic [IDX_W-1:0]     r_owner;
   logic [IDX_W-1:0]     r_rr_ptr;
   logic [AUX_WIDTH-1:0] r_owner_aux;

   // ---------------------------------------------------------------------------
   // Round-robin winner selection
   // ---------------------------------------------------------------------------
   logic             w_any_req;
   logic [IDX_W-1:0] w_winner;
   logic [IDX_W-1:0] w_idx;

   // Scan from r_rr_ptr upward with wrap-around; first hit wins. With no
   // request the winner stays 0 so master 0's payload is presented by default.
   always_comb begin
      w_any_req = 1'b0;
      w_winner  = '0;
      w_idx     = '0;
      for (int unsigned k = 0; k < N_MASTERS; k++) begin
         w_idx = IDX_W'((32'(r_rr_ptr) + k) % N_MASTERS);
         if (!w_any_req && m_req_i[w_idx]) begin
            w_any_req = 1'b1;
            w_winner  = w_idx;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Payload mux towards the bridge
   // ---------------------------------------------------------------------------
   logic [AUX_WIDTH-1:0] w_win_aux;

   always_comb begin
      per_add_o   = m_add_i[ADDR_WIDTH-1:0];
      per_wen_o   = m_wen_i[0];
      per_wdata_o = m_wdata_i[DATA_WIDTH-1:0];
      per_wtag_o  = m_wtag_i[TAG_WIDTH-1:0];
      per_be_o    = m_be_i[BE_WIDTH-1:0];
      w_win_aux   = m_aux_i[AUX_WIDTH-1:0];
      for (int unsigned k = 1; k < N_MASTERS; k++) begin
         if (w_winner == IDX_W'(k)) begin
            per_add_o   = m_add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            per_wen_o   = m_wen_i[k];
            per_wdata_o = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            per_wtag_o  = m_wtag_i[k*TAG_WIDTH +: TAG_WIDTH];
            per_be_o    = m_be_i[k*BE_WIDTH +: BE_WIDTH];
            w_win_aux   = m_aux_i[k*AUX_WIDTH +: AUX_WIDTH];
         end
      end
   end

   assign per_aux_o = w_win_aux;

   // ---------------------------------------------------------------------------
   // Arbitration and handshake
   // ---------------------------------------------------------------------------
   logic w_arb_en;
   logic w_grant;
   logic w_resp;

   // Arbitration is also open in WAIT_RESP on the response cycle, which lets
   // the next transaction be granted while the current one retires.
   assign w_arb_en  = (r_cs == ST_IDLE) | ((r_cs == ST_WAIT) & per_r_valid_i);
   assign per_req_o = w_arb_en & w_any_req;
   assign w_grant   = per_req_o & per_gnt_i;
   assign w_resp    = (r_cs == ST_WAIT) & per_r_valid_i;

   always_comb begin
      for (int unsigned k = 0; k < N_MASTERS; k++) begin
         m_gnt_o[k] = w_grant & (w_winner == IDX_W'(k));
      end
   end

`ifdef L2_PER_ARB_TIMEOUT_EN
   // ---------------------------------------------------------------------------
   // Response watchdog
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] r_cnt;
   logic             w_timeout;

   // Firing one count early places ERR_RESP exactly TIMEOUT_CYCLES cycles
   // after the last WAIT_RESP entry.
   assign w_timeout = (r_cs == ST_WAIT) & ~per_r_valid_i &
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_grant) begin
         r_cnt <= '0;
      end else if ((r_cs == ST_WAIT) && !per_r_valid_i) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      w_cs_next = r_cs;
      case (r_cs)
         ST_IDLE: begin
            if (w_grant) w_cs_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_grant) begin
               w_cs_next = ST_WAIT;
            end else if (per_r_valid_i) begin
               w_cs_next = ST_IDLE;
`ifdef L2_PER_ARB_TIMEOUT_EN
            end else if (w_timeout) begin
               w_cs_next = ST_ERR;
`endif
            end
         end
`ifdef L2_PER_ARB_TIMEOUT_EN
         ST_ERR:  w_cs_next = ST_IDLE;
`endif
         default: w_cs_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs        <= ST_IDLE;
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_owner_aux <= '0;
      end else begin
         r_cs <= w_cs_next;
         if (w_grant) begin
            r_owner     <= w_winner;
            r_owner_aux <= w_win_aux;
            r_rr_ptr    <= (w_winner == IDX_W'(N_MASTERS - 1)) ? '0 : w_winner + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Response routing
   // ---------------------------------------------------------------------------
   logic w_route;

`ifdef L2_PER_ARB_TIMEOUT_EN
   assign w_route = w_resp | (r_cs == ST_ERR);
`else
   assign w_route = w_resp;
`endif

   always_comb begin
      for (int unsigned k = 0; k < N_MASTERS; k++) begin
         m_r_valid_o[k] = w_route & (r_owner == IDX_W'(k));
      end
   end

   // Payload is broadcast; only the valid bits are per master.
   always_comb begin
      m_r_rdata_o = per_r_rdata_i;
      m_r_rtag_o  = per_r_rtag_i;
      m_r_opc_o   = per_r_opc_i;
      m_r_aux_o   = per_r_aux_i;
`ifdef L2_PER_ARB_TIMEOUT_EN
      if (r_cs == ST_ERR) begin
         m_r_rdata_o = ERR_RDATA;
         m_r_rtag_o  = '1;
         m_r_opc_o   = 1'b1;
         m_r_aux_o   = r_owner_aux;
      end
`endif
   end

   // test_en_i has no function here; the owner aux is only read by the watchdog.
   logic w_unused_cfg;
`ifdef L2_PER_ARB_TIMEOUT_EN
   assign w_unused_cfg = test_en_i;
`else
   assign w_unused_cfg = ^{test_en_i, r_owner_aux, (TIMEOUT_CYCLES == 0)};
`endif

endmodule

// File: tb/tb_l2_per_bridge_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_per_bridge_arbiter
//
// Bench for l2_per_bridge_arbiter (N_MASTERS=4, 32-bit data, TIMEOUT_CYCLES=8).
// Directed vector table, reset/timeout sequences, then random stimulus against
// a transaction-level model (busy flag, owner, next-priority pointer).
// -----------------------------------------------------------------------------
module tb_l2_per_bridge_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int TW = DW / 8;
   localparam int XW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            test_en;
   logic [N-1:0]    m_req;
   logic [N*AW-1:0] m_add;
   logic [N-1:0]    m_wen;
   logic [N*DW-1:0] m_wdata;
   logic [N*TW-1:0] m_wtag;
   logic [N*BW-1:0] m_be;
   logic [N*XW-1:0] m_aux;
   logic [N-1:0]    m_gnt;
   logic [N-1:0]    m_r_valid;
   logic [DW-1:0]   m_r_rdata;
   logic [TW-1:0]   m_r_rtag;
   logic            m_r_opc;
   logic [XW-1:0]   m_r_aux;
   logic            per_req;
   logic [AW-1:0]   per_add;
   logic            per_wen;
   logic [DW-1:0]   per_wdata;
   logic [TW-1:0]   per_wtag;
   logic [BW-1:0]   per_be;
   logic [XW-1:0]   per_aux;
   logic            per_gnt;
   logic            per_r_valid;
   logic [DW-1:0]   per_r_rdata;
   logic [TW-1:0]   per_r_rtag;
   logic            per_r_opc;
   logic [XW-1:0]   per_r_aux;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   l2_per_bridge_arbiter #(
      .N_MASTERS      (N),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .BE_WIDTH       (BW),
      .TAG_WIDTH      (TW),
      .AUX_WIDTH      (XW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .test_en_i     (test_en),
      .m_req_i       (m_req),
      .m_add_i       (m_add),
      .m_wen_i       (m_wen),
      .m_wdata_i     (m_wdata),
      .m_wtag_i      (m_wtag),
      .m_be_i        (m_be),
      .m_aux_i       (m_aux),
      .m_gnt_o       (m_gnt),
      .m_r_valid_o   (m_r_valid),
      .m_r_rdata_o   (m_r_rdata),
      .m_r_rtag_o    (m_r_rtag),
      .m_r_opc_o     (m_r_opc),
      .m_r_aux_o     (m_r_aux),
      .per_req_o     (per_req),
      .per_add_o     (per_add),
      .per_wen_o     (per_wen),
      .per_wdata_o   (per_wdata),
      .per_wtag_o    (per_wtag),
      .per_be_o      (per_be),
      .per_aux_o     (per_aux),
      .per_gnt_i     (per_gnt),
      .per_r_valid_i (per_r_valid),
      .per_r_rdata_i (per_r_rdata),
      .per_r_rtag_i  (per_r_rtag),
      .per_r_opc_i   (per_r_opc),
      .per_r_aux_i   (per_r_aux)
   );

   typedef struct {
      logic [3:0]  req;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        exp_req;
      logic [3:0]  exp_gnt;
      logic [3:0]  exp_rv;
      logic        add_chk;
      logic [31:0] exp_add;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add_vec(input logic [3:0] req, input logic gnt, input logic rv,
                          input logic [31:0] rdata, input logic exp_req,
                          input logic [3:0] exp_gnt, input logic [3:0] exp_rv,
                          input logic add_chk, input logic [31:0] exp_add);
      vec_t v;
      v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
      v.exp_req = exp_req; v.exp_gnt = exp_gnt; v.exp_rv = exp_rv;
      v.add_chk = add_chk; v.exp_add = exp_add;
      vecs.push_back(v);
   endtask

   // Fixed, easily recognisable payload per master: addr A000_000k, aux k+1.
   task automatic fixed_payload();
      for (int k = 0; k < N; k++) begin
         m_add[k*AW +: AW]   = 32'hA000_0000 + k;
         m_wdata[k*DW +: DW] = 32'hD000_0000 + k;
         m_wtag[k*TW +: TW]  = 4'(k);
         m_be[k*BW +: BW]    = 4'hF;
         m_aux[k*XW +: XW]   = 4'(k + 1);
         m_wen[k]            = k[0];
      end
   endtask

   task automatic drive(input logic [3:0] req, input logic gnt, input logic rv,
                        input logic [31:0] rdata);
      m_req       = req;
      per_gnt     = gnt;
      per_r_valid = rv;
      per_r_rdata = rdata;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      advance();
   endtask

   // Transaction-level reference model state
   int          m_busy, m_owner, m_ptr, m_wait;
   logic [31:0] exp_rdata;

   initial begin
      rst_n     = 1'b0;
      test_en   = 1'b0;
      m_req     = '0;
      fixed_payload();
      per_gnt     = 1'b0;
      per_r_valid = 1'b1;
      per_r_rdata = 32'h0;
      per_r_rtag  = '0;
      per_r_opc   = 1'b1;
      per_r_aux   = '0;

      // ---------------- reset values (checked while reset is asserted) -------
      #12;
      chk("reset_per_req", 64'(per_req), 64'd0);
      chk("reset_gnt", 64'(m_gnt), 64'd0);
      chk("reset_rvalid", 64'(m_r_valid), 64'd0);
      chk("reset_opc_pass", 64'(m_r_opc), 64'd1);
      per_r_valid = 1'b0;
      per_r_opc   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      advance();

      // ---------------- directed vector table ---------------------------------
      // single request, master 2
      add_vec(4'b0100, 1, 0, 32'h0,         1, 4'b0100, 4'b0000, 1, 32'hA000_0002);
      add_vec(4'b0000, 0, 0, 32'h0,         0, 4'b0000, 4'b0000, 1, 32'hA000_0000);
      add_vec(4'b0000, 0, 0, 32'h0,         0, 4'b0000, 4'b0000, 1, 32'hA000_0000);
      add_vec(4'b0000, 0, 1, 32'h1234_5678, 0, 4'b0000, 4'b0100, 1, 32'hA000_0000);
      // spurious response in IDLE
      add_vec(4'b0000, 0, 1, 32'hDEAD_BEEF, 0, 4'b0000, 4'b0000, 1, 32'hA000_0000);
      // grant stall, master 1 (spurious response mid-stall)
      add_vec(4'b0010, 0, 0, 32'h0,         1, 4'b0000, 4'b0000, 1, 32'hA000_0001);
      add_vec(4'b0010, 0, 0, 32'h0,         1, 4'b0000, 4'b0000, 1, 32'hA000_0001);
      add_vec(4'b0010, 0, 1, 32'h5555_0000, 1, 4'b0000, 4'b0000, 1, 32'hA000_0001);
      add_vec(4'b0010, 0, 0, 32'h0,         1, 4'b0000, 4'b0000, 1, 32'hA000_0001);
      add_vec(4'b0010, 0, 0, 32'h0,         1, 4'b0000, 4'b0000, 1, 32'hA000_0001);
      add_vec(4'b0010, 1, 0, 32'h0,         1, 4'b0010, 4'b0000, 1, 32'hA000_0001);
      add_vec(4'b0000, 0, 1, 32'h0000_0011, 0, 4'b0000, 4'b0010, 1, 32'hA000_0000);
      // master 3 alone brings the pointer back to 0
      add_vec(4'b1000, 1, 0, 32'h0,         1, 4'b1000, 4'b0000, 1, 32'hA000_0003);
      // round robin, all requesting, grant + response every cycle
      add_vec(4'b1111, 1, 1, 32'h0000_0100, 1, 4'b0001, 4'b1000, 1, 32'hA000_0000);
      add_vec(4'b1111, 1, 1, 32'h0000_0101, 1, 4'b0010, 4'b0001, 1, 32'hA000_0001);
      add_vec(4'b1111, 1, 1, 32'h0000_0102, 1, 4'b0100, 4'b0010, 1, 32'hA000_0002);
      add_vec(4'b1111, 1, 1, 32'h0000_0103, 1, 4'b1000, 4'b0100, 1, 32'hA000_0003);
      add_vec(4'b1111, 1, 1, 32'h0000_0104, 1, 4'b0001, 4'b1000, 1, 32'hA000_0000);
      // back-to-back: response to 0 with a new grant to 3
      add_vec(4'b1000, 1, 1, 32'h0000_0200, 1, 4'b1000, 4'b0001, 1, 32'hA000_0003);
      // still waiting: no arbitration without a response
      add_vec(4'b0001, 1, 0, 32'h0,         0, 4'b0000, 4'b0000, 0, 32'h0);
      add_vec(4'b0000, 0, 1, 32'h0000_0300, 0, 4'b0000, 4'b1000, 1, 32'hA000_0000);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
         @(negedge clk);
         chk($sformatf("vec%0d_per_req", i), 64'(per_req), 64'(vecs[i].exp_req));
         chk($sformatf("vec%0d_gnt", i), 64'(m_gnt), 64'(vecs[i].exp_gnt));
         chk($sformatf("vec%0d_rvalid", i), 64'(m_r_valid), 64'(vecs[i].exp_rv));
         chk($sformatf("vec%0d_rdata", i), 64'(m_r_rdata), 64'(vecs[i].rdata));
         if (vecs[i].add_chk)
            chk($sformatf("vec%0d_per_add", i), 64'(per_add), 64'(vecs[i].exp_add));
         advance();
      end

      // ---------------- reset in the middle of a transaction ------------------
      drive(4'b0100, 1, 0, 32'h0);
      @(negedge clk);
      chk("midrst_grant", 64'(m_gnt), 64'b0100);
      advance();
      drive(4'b0000, 0, 0, 32'h0);
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      advance();
      drive(4'b0000, 0, 1, 32'hCAFE_0000);
      @(negedge clk);
      chk("midrst_resp_dropped", 64'(m_r_valid), 64'd0);
      advance();
      // pointer back at 0 after reset
      drive(4'b1111, 1, 0, 32'h0);
      @(negedge clk);
      chk("midrst_ptr_zero", 64'(m_gnt), 64'b0001);
      advance();
      drive(4'b0000, 0, 1, 32'h0);
      @(negedge clk);
      chk("midrst_resp0", 64'(m_r_valid), 64'b0001);
      advance();

`ifdef L2_PER_ARB_TIMEOUT_EN
      // ---------------- response watchdog -------------------------------------
      m_aux[1*XW +: XW] = 4'h5;
      per_r_rtag = '0;
      per_r_aux  = '0;
      per_r_opc  = 1'b0;
      drive(4'b0010, 1, 0, 32'h0);
      @(negedge clk);
      chk("to_grant", 64'(m_gnt), 64'b0010);
      advance();
      for (int c = 1; c <= 8; c++) begin
         drive(4'b0000, 0, 0, 32'h0);
         @(negedge clk);
         chk($sformatf("to_wait%0d_rvalid", c), 64'(m_r_valid), 64'd0);
         advance();
      end
      @(negedge clk);
      chk("to_err_rvalid", 64'(m_r_valid), 64'b0010);
      chk("to_err_opc", 64'(m_r_opc), 64'd1);
      chk("to_err_rdata", 64'(m_r_rdata), 64'hBADA_CCE5);
      chk("to_err_rtag", 64'(m_r_rtag), 64'hF);
      chk("to_err_aux", 64'(m_r_aux), 64'h5);
      advance();
      drive(4'b0001, 1, 1, 32'h7777_7777);
      @(negedge clk);
      chk("to_idle_grant", 64'(m_gnt), 64'b0001);
      chk("to_late_dropped", 64'(m_r_valid), 64'd0);
      advance();
      fixed_payload();
`endif

      // ---------------- random stimulus vs. reference model ------------------
      drive(4'b0000, 0, 0, 32'h0);
      do_reset();
      m_busy = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
      for (int c = 0; c < 400; c++) begin
         logic [3:0]  req, eg, erv;
         logic        g, rv, ereq, found;
         int          win;
         logic [31:0] eadd, ewd;

         req = 4'($urandom_range(0, 15));
         g   = ($urandom_range(0, 3) != 0);
         rv  = (m_busy != 0 && m_wait >= 4) ? 1'b1 : ($urandom_range(0, 2) == 0);
         for (int k = 0; k < N; k++) begin
            m_add[k*AW +: AW]   = $urandom;
            m_wdata[k*DW +: DW] = $urandom;
            m_aux[k*XW +: XW]   = 4'($urandom_range(0, 15));
         end
         exp_rdata  = $urandom;
         per_r_opc  = 1'($urandom_range(0, 1));
         per_r_aux  = 4'($urandom_range(0, 15));
         per_r_rtag = 4'($urandom_range(0, 15));
         drive(req, g, rv, exp_rdata);

         // highest priority goes to the master just after the last one served
         found = 1'b0;
         win   = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && req[(m_ptr + k) % N]) begin
               found = 1'b1;
               win   = (m_ptr + k) % N;
            end
         end
         ereq = found && (m_busy == 0 || rv);
         eg   = (ereq && g) ? 4'(1 << win) : 4'b0;
         erv  = (m_busy != 0 && rv) ? 4'(1 << m_owner) : 4'b0;
         eadd = m_add[win*AW +: AW];
         ewd  = m_wdata[win*DW +: DW];

         @(negedge clk);
         chk($sformatf("rnd%0d_per_req", c), 64'(per_req), 64'(ereq));
         chk($sformatf("rnd%0d_gnt", c), 64'(m_gnt), 64'(eg));
         chk($sformatf("rnd%0d_rvalid", c), 64'(m_r_valid), 64'(erv));
         chk($sformatf("rnd%0d_rdata", c), 64'(m_r_rdata), 64'(exp_rdata));
         chk($sformatf("rnd%0d_opc", c), 64'(m_r_opc), 64'(per_r_opc));
         if (ereq || req == 4'b0) begin
            chk($sformatf("rnd%0d_per_add", c), 64'(per_add), 64'(eadd));
            chk($sformatf("rnd%0d_per_wdata", c), 64'(per_wdata), 64'(ewd));
         end
         advance();

         if (ereq && g) begin
            m_owner = win;
            m_ptr   = (win + 1) % N;
            m_busy  = 1;
            m_wait  = 0;
         end else if (m_busy != 0 && rv) begin
            m_busy = 0;
         end else if (m_busy != 0) begin
            m_wait++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
